// File: rtl/uart_tx_if.sv
// Byte-level transmit interface between a serial byte client and uart_tx.
// Handshake: the client may pulse txStart for one cycle whenever it has seen
// txBusy low; the byte on txData is taken on that edge only. txBusy rises on
// the following edge, so seeing txBusy high one cycle after the pulse means
// the byte was accepted. txStart while txBusy is high is ignored.
interface uart_tx_if;
   logic       txStart;
   logic [7:0] txData;
   logic       txBusy;
   logic       tx;

   modport master (output txStart, output txData, input txBusy, input tx);
   modport slave  (input txStart, input txData, output txBusy, output tx);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity bit,
// one or two stop bits. tx and txBusy come straight from flops.
module uart_tx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   uart_tx_if.slave     bus,
   output logic [2:0]   dbg_state
);

   localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [W-1:0] BAUD_LAST = W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      PAR   = 3'd3,
      STOP  = 3'd4
   } state_t;

   state_t       state_q, state_n;
   logic [W-1:0] baud_q, baud_n;
   logic [2:0]   idx_q, idx_n;
   logic         stop_q, stop_n;
   logic [7:0]   sh_q, sh_n;
   logic         par_q, par_n;
   logic         tx_q, tx_n;
   logic         busy_q, busy_n;
   logic         baud_end;

   assign baud_end   = (baud_q == BAUD_LAST);
   assign bus.tx     = tx_q;
   assign bus.txBusy = busy_q;
   assign dbg_state  = state_q;

   // State and datapath registers; reset aborts any frame in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         baud_q  <= '0;
         idx_q   <= '0;
         stop_q  <= 1'b0;
         sh_q    <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         baud_q  <= baud_n;
         idx_q   <= idx_n;
         stop_q  <= stop_n;
         sh_q    <= sh_n;
         par_q   <= par_n;
         tx_q    <= tx_n;
         busy_q  <= busy_n;
      end
   end

   // Next state plus the line level / busy flag for the coming cycle, so the
   // outputs can be registered without adding a cycle of latency.
   always_comb begin
      state_n = state_q;
      baud_n  = baud_q;
      idx_n   = idx_q;
      stop_n  = stop_q;
      sh_n    = sh_q;
      par_n   = par_q;
      tx_n    = tx_q;
      busy_n  = busy_q;

      case (state_q)
         IDLE: begin
            tx_n   = 1'b1;
            busy_n = 1'b0;
            baud_n = '0;
            if (bus.txStart) begin
               sh_n    = bus.txData;
               par_n   = (PARITY == 1) ? ~(^bus.txData) : (^bus.txData);
               state_n = START;
               tx_n    = 1'b0;
               busy_n  = 1'b1;
            end
         end
         START: begin
            if (baud_end) begin
               baud_n  = '0;
               idx_n   = 3'd0;
               state_n = DATA;
               tx_n    = sh_q[0];
            end else begin
               baud_n = baud_q + W'(1);
            end
         end
         DATA: begin
            if (baud_end) begin
               baud_n = '0;
               if (idx_q == 3'd7) begin
                  stop_n = 1'b0;
                  if (PARITY != 0) begin
                     state_n = PAR;
                     tx_n    = par_q;
                  end else begin
                     state_n = STOP;
                     tx_n    = 1'b1;
                  end
               end else begin
                  idx_n = idx_q + 3'd1;
                  sh_n  = {1'b0, sh_q[7:1]};
                  tx_n  = sh_q[1];
               end
            end else begin
               baud_n = baud_q + W'(1);
            end
         end
         PAR: begin
            if (baud_end) begin
               baud_n  = '0;
               stop_n  = 1'b0;
               state_n = STOP;
               tx_n    = 1'b1;
            end else begin
               baud_n = baud_q + W'(1);
            end
         end
         STOP: begin
            tx_n = 1'b1;
            if (baud_end) begin
               baud_n = '0;
               if ((STOP_BITS == 2) && !stop_q) begin
                  stop_n = 1'b1;
               end else begin
                  stop_n  = 1'b0;
                  state_n = IDLE;
                  busy_n  = 1'b0;
               end
            end else begin
               baud_n = baud_q + W'(1);
            end
         end
         default: begin
            state_n = IDLE;
            baud_n  = '0;
            tx_n    = 1'b1;
            busy_n  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances covering parity none/even/odd and two
// stop bits, all checked against a frame model built from the bit layout.
module tb_uart_tx;

   localparam int CPB = 4;
   localparam int PAR_C[4]  = '{0, 2, 1, 2};
   localparam int STOP_C[4] = '{1, 1, 1, 2};

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] st = 4'b0;
   logic [7:0] data = 8'h00;
   logic       tx_o[4];
   logic       busy_o[4];
   logic [2:0] dbg0, dbg1, dbg2, dbg3;
   logic [7:0] exp_q[$];

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   uart_tx_if if0 ();
   uart_tx_if if1 ();
   uart_tx_if if2 ();
   uart_tx_if if3 ();

   assign if0.txStart = st[0];
   assign if1.txStart = st[1];
   assign if2.txStart = st[2];
   assign if3.txStart = st[3];
   assign if0.txData  = data;
   assign if1.txData  = data;
   assign if2.txData  = data;
   assign if3.txData  = data;
   assign tx_o[0] = if0.tx;
   assign tx_o[1] = if1.tx;
   assign tx_o[2] = if2.tx;
   assign tx_o[3] = if3.tx;
   assign busy_o[0] = if0.txBusy;
   assign busy_o[1] = if1.txBusy;
   assign busy_o[2] = if2.txBusy;
   assign busy_o[3] = if3.txBusy;

   uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1))
      dut0 (.clk(clk), .rst_n(rst_n), .bus(if0), .dbg_state(dbg0));
   uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1))
      dut1 (.clk(clk), .rst_n(rst_n), .bus(if1), .dbg_state(dbg1));
   uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1))
      dut2 (.clk(clk), .rst_n(rst_n), .bus(if2), .dbg_state(dbg2));
   uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(2))
      dut3 (.clk(clk), .rst_n(rst_n), .bus(if3), .dbg_state(dbg3));

   // Frame length in cycles for configuration i.
   function automatic int frame_len(input int i);
      return CPB * (1 + 8 + ((PAR_C[i] != 0) ? 1 : 0) + STOP_C[i]);
   endfunction

   // Expected line level k cycles after the acceptance edge.
   function automatic logic exp_tx(input int i, input logic [7:0] d, input int k);
      int  b;
      int  ones;
      b = k / CPB;
      ones = 0;
      for (int j = 0; j < 8; j++) ones += int'(d[j]);
      if (b == 0) return 1'b0;
      if (b <= 8) return d[b-1];
      if (PAR_C[i] != 0 && b == 9) begin
         if (PAR_C[i] == 1) return ((ones % 2) == 0) ? 1'b1 : 1'b0;
         else               return ((ones % 2) == 1) ? 1'b1 : 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("%s_tx_d%0d", tag, i), {7'd0, tx_o[i]}, 8'h01);
         check($sformatf("%s_busy_d%0d", tag, i), {7'd0, busy_o[i]}, 8'h00);
      end
   endtask

   // Send one byte on the selected instances and follow the whole frame.
   // inj_k >= 0 pulses txStart with 0xFF that many cycles into the frame.
   task automatic run_frame(input logic [3:0] mask, input logic [7:0] d, input int inj_k);
      int         fl[4];
      int         maxf;
      logic [7:0] rx[4];
      logic [7:0] want;
      maxf = 0;
      exp_q.push_back(d);
      for (int i = 0; i < 4; i++) begin
         fl[i] = frame_len(i);
         rx[i] = 8'h00;
         if (mask[i] && fl[i] > maxf) maxf = fl[i];
      end
      data = d;
      st = mask;
      tick();
      st = 4'b0;
      for (int k = 0; k <= maxf; k++) begin
         for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
               if (k < fl[i]) begin
                  check($sformatf("tx_d%0d_%0h_k%0d", i, d, k), {7'd0, tx_o[i]}, {7'd0, exp_tx(i, d, k)});
                  check($sformatf("busy_d%0d_%0h_k%0d", i, d, k), {7'd0, busy_o[i]}, 8'h01);
               end else begin
                  check($sformatf("idle_tx_d%0d_%0h_k%0d", i, d, k), {7'd0, tx_o[i]}, 8'h01);
                  check($sformatf("idle_busy_d%0d_%0h_k%0d", i, d, k), {7'd0, busy_o[i]}, 8'h00);
               end
               if (k >= CPB && k < 9 * CPB && (k % CPB) == CPB / 2)
                  rx[i][k/CPB-1] = tx_o[i];
            end
         end
         if (k == inj_k) begin
            st = mask;
            data = 8'hFF;
         end else begin
            st = 4'b0;
         end
         if (k < maxf) tick();
      end
      st = 4'b0;
      want = exp_q.pop_front();
      for (int i = 0; i < 4; i++)
         if (mask[i]) check($sformatf("rx_byte_d%0d", i), rx[i], want);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int gap;
      logic [7:0] rb;

      // Reset held with a start request pending.
      rst_n = 1'b0;
      st = 4'hF;
      data = 8'h55;
      for (int c = 0; c < 3; c++) begin
         tick();
         check_idle("reset");
      end
      st = 4'b0;
      rst_n = 1'b1;
      check("dbg_state_reset", {5'd0, dbg0}, 8'h00);
      check("dbg_state_reset3", {5'd0, dbg3}, 8'h00);
      for (int c = 0; c < 6; c++) begin
         tick();
         check_idle("post_reset");
      end

      // Single byte, no parity.
      run_frame(4'b0001, 8'hA5, -1);
      tick();

      // Start request with different data in mid-frame must be ignored.
      run_frame(4'b0001, 8'hA5, 10);
      for (int c = 0; c < 3; c++) begin
         tick();
         check_idle("after_reject");
      end

      // Back-to-back stream: next strobe on the first idle cycle.
      run_frame(4'b0001, 8'h01, -1);
      run_frame(4'b0001, 8'h02, -1);
      run_frame(4'b0001, 8'h03, -1);
      tick();

      // Parity and stop-bit variants with 0x07.
      run_frame(4'b1110, 8'h07, -1);
      tick();

      // Random bytes on all instances with random idle gaps.
      for (int n = 0; n < 6; n++) begin
         rb = 8'($urandom);
         run_frame(4'hF, rb, ((n % 2) == 1) ? int'($urandom_range(5, 30)) : -1);
         gap = int'($urandom_range(0, 3));
         for (int c = 0; c < gap; c++) begin
            tick();
            check_idle("rand_gap");
         end
      end
      tick();

      // Reset in the middle of a frame.
      data = 8'h3C;
      st = 4'b0001;
      tick();
      st = 4'b0;
      for (int k = 0; k < 15; k++) begin
         check($sformatf("pre_rst_tx_k%0d", k), {7'd0, tx_o[0]}, {7'd0, exp_tx(0, 8'h3C, k)});
         check($sformatf("pre_rst_busy_k%0d", k), {7'd0, busy_o[0]}, 8'h01);
         tick();
      end
      rst_n = 1'b0;
      tick();
      check_idle("mid_reset");
      rst_n = 1'b1;
      for (int c = 0; c < 2; c++) begin
         tick();
         check_idle("after_mid_reset");
      end
      run_frame(4'b0001, 8'h81, -1);

      check("scoreboard_empty", 8'(exp_q.size()), 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
